// File: rtl/i2c_slave_regif.sv
// I2C target that maps bus transfers onto an 8-bit-addressed local register file.
// It uses open-drain SDA (drive value fixed at 0) and glitch-filtered SCL/SDA inputs.
module i2c_slave_regif #(
  parameter logic [6:0]  DEV_ADDR = 7'h3C,
  parameter int unsigned FILT_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2c_scl,
  input  logic       i2c_sda_i,
  output logic       i2c_sda_o,
  output logic       i2c_sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_req,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  localparam int unsigned CntW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FILT_LEN - 1);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StReg, StRegAck,
    StWdata, StWdataAck, StRdata, StRdataAck, StWait
  } state_e;

  logic [1:0]      scl_sync_q, sda_sync_q;
  logic            scl_filt_q, sda_filt_q, scl_prev_q, sda_prev_q;
  logic [CntW-1:0] scl_cnt_q, sda_cnt_q;

  // A filtered level only follows the synchronised line after FILT_LEN differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      scl_cnt_q  <= '0;
      sda_cnt_q  <= '0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], i2c_scl};
      sda_sync_q <= {sda_sync_q[0], i2c_sda_i};
      scl_prev_q <= scl_filt_q;
      sda_prev_q <= sda_filt_q;
      if (scl_sync_q[1] == scl_filt_q) begin
        scl_cnt_q <= '0;
      end else if (scl_cnt_q == CntMax) begin
        scl_filt_q <= scl_sync_q[1];
        scl_cnt_q  <= '0;
      end else begin
        scl_cnt_q <= scl_cnt_q + 1'b1;
      end
      if (sda_sync_q[1] == sda_filt_q) begin
        sda_cnt_q <= '0;
      end else if (sda_cnt_q == CntMax) begin
        sda_filt_q <= sda_sync_q[1];
        sda_cnt_q  <= '0;
      end else begin
        sda_cnt_q <= sda_cnt_q + 1'b1;
      end
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_filt_q & ~scl_prev_q;
  assign scl_fall  = ~scl_filt_q & scl_prev_q;
  assign start_det = scl_filt_q & scl_prev_q & sda_prev_q & ~sda_filt_q;
  assign stop_det  = scl_filt_q & scl_prev_q & ~sda_prev_q & sda_filt_q;

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       oe_q, oe_d;
  logic       rw_q, rw_d;
  logic       mack_q, mack_d;
  logic       busy_q, busy_d;
  logic       rd_pend_q, rd_pend_d;
  logic       drive_pend_q, drive_pend_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       rd_req_q, rd_req_d;
  logic [7:0] rd_addr_q, rd_addr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      ptr_q        <= '0;
      oe_q         <= 1'b0;
      rw_q         <= 1'b0;
      mack_q       <= 1'b1;
      busy_q       <= 1'b0;
      rd_pend_q    <= 1'b0;
      drive_pend_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rd_req_q     <= 1'b0;
      rd_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      ptr_q        <= ptr_d;
      oe_q         <= oe_d;
      rw_q         <= rw_d;
      mack_q       <= mack_d;
      busy_q       <= busy_d;
      rd_pend_q    <= rd_pend_d;
      drive_pend_q <= drive_pend_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      rd_req_q     <= rd_req_d;
      rd_addr_q    <= rd_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    ptr_d        = ptr_q;
    oe_d         = oe_q;
    rw_d         = rw_q;
    mack_d       = mack_q;
    busy_d       = busy_q;
    drive_pend_d = drive_pend_q;
    rd_pend_d    = rd_req_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    rd_req_d     = 1'b0;
    rd_addr_d    = rd_addr_q;

    // Read data lands one cycle after rd_req; on a follow-on byte bit 7 is driven from it at once.
    if (rd_pend_q) begin
      if (drive_pend_q && state_q == StRdata) begin
        shift_d      = {rd_data[6:0], 1'b0};
        oe_d         = ~rd_data[7];
        drive_pend_d = 1'b0;
      end else begin
        shift_d = rd_data;
      end
    end

    if (start_det) begin
      state_d      = StAddr;
      bit_cnt_d    = '0;
      oe_d         = 1'b0;
      busy_d       = 1'b1;
      drive_pend_d = 1'b0;
    end else if (stop_det) begin
      state_d      = StIdle;
      bit_cnt_d    = '0;
      oe_d         = 1'b0;
      busy_d       = 1'b0;
      drive_pend_d = 1'b0;
    end else begin
      case (state_q)
        StAddr, StReg, StWdata: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[6:0], sda_filt_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            if (state_q == StAddr) begin
              if (shift_q[7:1] == DEV_ADDR) begin
                state_d = StAddrAck;
                oe_d    = 1'b1;
                rw_d    = shift_q[0];
                if (shift_q[0]) begin
                  rd_req_d  = 1'b1;
                  rd_addr_d = ptr_q;
                end
              end else begin
                state_d = StWait;
                oe_d    = 1'b0;
              end
            end else if (state_q == StReg) begin
              ptr_d   = shift_q;
              oe_d    = 1'b1;
              state_d = StRegAck;
            end else begin
              wr_en_d   = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = shift_q;
              oe_d      = 1'b1;
              state_d   = StWdataAck;
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            if (rw_q) begin
              state_d   = StRdata;
              oe_d      = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = 4'd1;
            end else begin
              state_d   = StReg;
              oe_d      = 1'b0;
              bit_cnt_d = '0;
            end
          end
        end
        StRegAck: begin
          if (scl_fall) begin
            state_d   = StWdata;
            oe_d      = 1'b0;
            bit_cnt_d = '0;
          end
        end
        StWdataAck: begin
          if (scl_fall) begin
            state_d   = StWdata;
            oe_d      = 1'b0;
            ptr_d     = ptr_q + 8'd1;
            bit_cnt_d = '0;
          end
        end
        StRdata: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d = StRdataAck;
              oe_d    = 1'b0;
            end else begin
              oe_d      = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        StRdataAck: begin
          if (scl_rise) begin
            mack_d = sda_filt_q;
          end else if (scl_fall) begin
            if (!mack_q) begin
              state_d      = StRdata;
              ptr_d        = ptr_q + 8'd1;
              rd_req_d     = 1'b1;
              rd_addr_d    = ptr_q + 8'd1;
              drive_pend_d = 1'b1;
              bit_cnt_d    = 4'd1;
            end else begin
              state_d = StWait;
              oe_d    = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign i2c_sda_o  = 1'b0;
  assign i2c_sda_oe = oe_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign rd_req     = rd_req_q;
  assign rd_addr    = rd_addr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Directed bench for i2c_slave_regif: bus-master tasks drive SCL/SDA, and a scoreboard
// checks register strobes and read bytes.
module tb_i2c_slave_regif;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_line;
  logic       sda_o, sda_oe, wr_en, rd_req, busy;
  logic [7:0] wr_addr, wr_data, rd_addr;
  logic [7:0] rd_data = 8'h00;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  exp_byte[$];
  logic        oe_seen = 1'b0;

  assign sda_line = m_sda & ~sda_oe;

  i2c_slave_regif dut (
    .clk        (clk),
    .rst        (rst),
    .i2c_scl    (m_scl),
    .i2c_sda_i  (sda_line),
    .i2c_sda_o  (sda_o),
    .i2c_sda_oe (sda_oe),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Register file model: mem[a] = ~a, returned the cycle after rd_req.
  always @(posedge clk) if (rd_req) rd_data <= ~rd_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1'b1;
    if (wr_en && rd_req) check("wr_rd_exclusive", 32'd1, 32'd0);
    if (wr_en) begin
      check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
      if (exp_wr.size() != 0) check("wr_addr_data", {16'd0, wr_addr, wr_data}, 32'(exp_wr.pop_front()));
    end
    if (rd_req) begin
      check("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
      if (exp_rd.size() != 0) check("rd_addr", 32'(rd_addr), 32'(exp_rd.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
    tick(4);
  endtask

  task automatic write_bit_g(input logic b, input logic gscl, input logic gsda);
    m_sda = b; tick(Q);
    m_scl = 1'b1; tick(4);
    if (gscl) begin m_scl = 1'b0; tick(2); m_scl = 1'b1; end else tick(2);
    if (gsda) begin m_sda = ~b; tick(2); m_sda = b; end else tick(2);
    tick(2 * Q - 8);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    b = sda_line; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic send_byte_g(input logic [7:0] d, input logic [7:0] gscl, input logic [7:0] gsda,
                             output logic ack);
    for (int i = 7; i >= 0; i--) write_bit_g(d[i], gscl[i], gsda[i]);
    read_bit(ack);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    send_byte_g(d, 8'h00, 8'h00, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic [7:0] v;
    logic       b;
    v = '0;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
    write_bit_g(nack, 1'b0, 1'b0);
    d = v;
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [7:0] addr_w;

    // Reset state
    tick(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_oe", 32'(sda_oe), 32'd0);
    check("rst_sda_o", 32'(sda_o), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_rd_req", 32'(rd_req), 32'd0);
    rst = 1'b0;
    tick(5);

    // Write two bytes from reg 0x12
    exp_wr.push_back(16'h12A5);
    exp_wr.push_back(16'h135A);
    i2c_start();
    check("t1_busy_start", 32'(busy), 32'd1);
    send_byte(8'h78, ack); check("t1_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h12, ack); check("t1_reg_ack", 32'(ack), 32'd0);
    send_byte(8'hA5, ack); check("t1_d0_ack", 32'(ack), 32'd0);
    send_byte(8'h5A, ack); check("t1_d1_ack", 32'(ack), 32'd0);
    i2c_stop();
    check("t1_busy_stop", 32'(busy), 32'd0);
    check("t1_wr_drained", 32'(exp_wr.size()), 32'd0);

    // Set pointer 0x40, repeated START, read three bytes
    exp_rd.push_back(8'h40);
    exp_rd.push_back(8'h41);
    exp_rd.push_back(8'h42);
    exp_byte.push_back(8'hBF);
    exp_byte.push_back(8'hBE);
    exp_byte.push_back(8'hBD);
    i2c_start();
    send_byte(8'h78, ack); check("t2_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h40, ack); check("t2_reg_ack", 32'(ack), 32'd0);
    i2c_start();
    send_byte(8'h79, ack); check("t2_raddr_ack", 32'(ack), 32'd0);
    for (int k = 0; k < 3; k++) begin
      recv_byte(k == 2, d);
      check("t2_rd_byte", 32'(d), 32'(exp_byte.pop_front()));
    end
    tick(4);
    check("t2_released", 32'(sda_oe), 32'd0);
    i2c_stop();
    check("t2_rd_drained", 32'(exp_rd.size()), 32'd0);

    // Foreign address: never drive SDA, no strobes
    oe_seen = 1'b0;
    i2c_start();
    send_byte(8'hA0, ack); check("t3_addr_nack", 32'(ack), 32'd1);
    send_byte(8'h11, ack); check("t3_d0_nack", 32'(ack), 32'd1);
    send_byte(8'h22, ack); check("t3_d1_nack", 32'(ack), 32'd1);
    check("t3_busy", 32'(busy), 32'd1);
    i2c_stop();
    check("t3_oe_quiet", 32'(oe_seen), 32'd0);
    check("t3_busy_stop", 32'(busy), 32'd0);

    // Pointer wrap
    exp_wr.push_back(16'hFF11);
    exp_wr.push_back(16'h0022);
    exp_wr.push_back(16'h0133);
    i2c_start();
    send_byte(8'h78, ack); check("t4_addr_ack", 32'(ack), 32'd0);
    send_byte(8'hFF, ack); check("t4_reg_ack", 32'(ack), 32'd0);
    send_byte(8'h11, ack);
    send_byte(8'h22, ack);
    send_byte(8'h33, ack); check("t4_d2_ack", 32'(ack), 32'd0);
    i2c_stop();
    check("t4_wr_drained", 32'(exp_wr.size()), 32'd0);

    // Short glitches on SCL and SDA while SCL is high
    exp_wr.push_back(16'h20C3);
    i2c_start();
    send_byte_g(8'h78, 8'b0010_0000, 8'b0001_0000, ack); check("t5_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h20, ack); check("t5_reg_ack", 32'(ack), 32'd0);
    send_byte_g(8'hC3, 8'b1000_0001, 8'b0100_0001, ack); check("t5_data_ack", 32'(ack), 32'd0);
    i2c_stop();
    check("t5_wr_drained", 32'(exp_wr.size()), 32'd0);

    // Reset while the address ACK is being driven
    i2c_start();
    addr_w = 8'h78;
    for (int i = 7; i >= 0; i--) write_bit_g(addr_w[i], 1'b0, 1'b0);
    m_sda = 1'b1;
    tick(Q);
    check("t6_ack_driven", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_release", 32'(sda_oe), 32'd0);
    tick(3);
    rst = 1'b0;
    tick(Q);
    check("t6_busy_after_rst", 32'(busy), 32'd0);
    exp_wr.push_back(16'h0577);
    i2c_start();
    send_byte(8'h78, ack); check("t6_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h05, ack); check("t6_reg_ack", 32'(ack), 32'd0);
    send_byte(8'h77, ack); check("t6_data_ack", 32'(ack), 32'd0);
    i2c_stop();
    check("t6_wr_drained", 32'(exp_wr.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
